// File: rtl/data_path.sv
// mini-SRC single-bus 32-bit datapath: register file, PC/IR/MAR/MDR/Y/Z, adder ALU, 512x32 memory.
// Memory starts zeroed.

module dp_reg #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clock or negedge clear) begin
    if (!clear)  q <= '0;
    else if (en) q <= d;
  end
endmodule

module data_path (
  input  logic        clock,
  input  logic        clear,
  input  logic        PCout,
  input  logic        Zlowout,
  input  logic        MDRout,
  input  logic        Rout,
  input  logic        BAout,
  input  logic        Csignout,
  input  logic        PCin,
  input  logic        IRin,
  input  logic        MARin,
  input  logic        MDRin,
  input  logic        Yin,
  input  logic        Zlowin,
  input  logic        Zhighin,
  input  logic        Rin,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  input  logic        IncPC,
  input  logic        ADD,
  input  logic        MD_read,
  input  logic        MAR_clear,
  input  logic        Read,
  input  logic        Write,
  output logic [31:0] BusMuxOut,
  output logic [31:0] IRval
);
  localparam int NUM_REGS = 16;

  logic [NUM_REGS-1:0][31:0] r_q;
  logic [31:0] pc_q, ir_q, mdr_q, y_q, zl_q, zh_q;
  logic [8:0]  mar_q, mar_d;
  logic [3:0]  ra, rb, rc, sel;
  logic [31:0] c_sext, bus, mdata, mdr_d;
  logic [32:0] sum;
  logic [63:0] alu;

  logic [31:0] mem [0:511] = '{default: 32'h0};

  // instruction field decode
  assign ra     = ir_q[26:23];
  assign rb     = ir_q[22:19];
  assign rc     = ir_q[18:15];
  assign c_sext = {{13{ir_q[18]}}, ir_q[18:0]};
  assign sel    = ({4{Gra}} & ra) | ({4{Grb}} & rb) | ({4{Grc}} & rc);

  always_comb begin
    bus = '0;
    if (clear) begin
      if (MDRout)        bus = mdr_q;
      else if (PCout)    bus = pc_q;
      else if (Zlowout)  bus = zl_q;
      else if (Rout)     bus = r_q[sel];
      else if (BAout)    bus = (sel == 4'd0) ? 32'h0 : r_q[sel];
      else if (Csignout) bus = c_sext;
    end
  end

  always_comb begin
    sum = '0;
    if (IncPC)    sum = {1'b0, bus} + 33'd1;
    else if (ADD) sum = {1'b0, y_q} + {1'b0, bus};
  end
  assign alu = {31'b0, sum};

  // read is combinational and sees the pre-write word on a shared edge
  assign mdata = Read ? mem[mar_q] : 32'h0;
  assign mdr_d = MD_read ? mdata : bus;
  assign mar_d = MAR_clear ? 9'd0 : bus[8:0];

  always_ff @(posedge clock) begin
    if (Write && clear) mem[mar_q] <= mdr_q;
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_r
    dp_reg #(.W(32)) u_r (
      .clock (clock),
      .clear (clear),
      .en    (Rin && (sel == 4'(g))),
      .d     (bus),
      .q     (r_q[g])
    );
  end

  dp_reg #(.W(32)) u_pc  (.clock(clock), .clear(clear), .en(PCin),              .d(bus),        .q(pc_q));
  dp_reg #(.W(32)) u_ir  (.clock(clock), .clear(clear), .en(IRin),              .d(bus),        .q(ir_q));
  dp_reg #(.W(9))  u_mar (.clock(clock), .clear(clear), .en(MARin | MAR_clear), .d(mar_d),      .q(mar_q));
  dp_reg #(.W(32)) u_mdr (.clock(clock), .clear(clear), .en(MDRin),             .d(mdr_d),      .q(mdr_q));
  dp_reg #(.W(32)) u_y   (.clock(clock), .clear(clear), .en(Yin),               .d(bus),        .q(y_q));
  dp_reg #(.W(32)) u_zl  (.clock(clock), .clear(clear), .en(Zlowin),            .d(alu[31:0]),  .q(zl_q));
  dp_reg #(.W(32)) u_zh  (.clock(clock), .clear(clear), .en(Zhighin),           .d(alu[63:32]), .q(zh_q));

  assign BusMuxOut = bus;
  assign IRval     = ir_q;
endmodule

// File: tb/tb_data_path.sv
// Bench for data_path: loads a program through the datapath itself, then runs fetch/execute
// microsequences against an instruction-level register model.

module tb_data_path;
   logic        clock, clear;
   logic [31:0] BusMuxOut, IRval;

   typedef logic [22:0] ctl_t;
   ctl_t ctl;

   localparam ctl_t C_PCOUT   = 23'(1) << 0;
   localparam ctl_t C_ZLOWOUT = 23'(1) << 1;
   localparam ctl_t C_MDROUT  = 23'(1) << 2;
   localparam ctl_t C_ROUT    = 23'(1) << 3;
   localparam ctl_t C_BAOUT   = 23'(1) << 4;
   localparam ctl_t C_CSIGN   = 23'(1) << 5;
   localparam ctl_t C_PCIN    = 23'(1) << 6;
   localparam ctl_t C_IRIN    = 23'(1) << 7;
   localparam ctl_t C_MARIN   = 23'(1) << 8;
   localparam ctl_t C_MDRIN   = 23'(1) << 9;
   localparam ctl_t C_YIN     = 23'(1) << 10;
   localparam ctl_t C_ZLOWIN  = 23'(1) << 11;
   localparam ctl_t C_ZHIGHIN = 23'(1) << 12;
   localparam ctl_t C_RIN     = 23'(1) << 13;
   localparam ctl_t C_GRA     = 23'(1) << 14;
   localparam ctl_t C_GRB     = 23'(1) << 15;
   localparam ctl_t C_GRC     = 23'(1) << 16;
   localparam ctl_t C_INCPC   = 23'(1) << 17;
   localparam ctl_t C_ADD     = 23'(1) << 18;
   localparam ctl_t C_MDREAD  = 23'(1) << 19;
   localparam ctl_t C_MARCLR  = 23'(1) << 20;
   localparam ctl_t C_READ    = 23'(1) << 21;
   localparam ctl_t C_WRITE   = 23'(1) << 22;
   localparam ctl_t C_MEMRD   = C_READ | C_MDREAD | C_MDRIN;

   localparam int NPROG = 49;

   data_path dut (
      .clock(clock), .clear(clear),
      .PCout(ctl[0]), .Zlowout(ctl[1]), .MDRout(ctl[2]), .Rout(ctl[3]), .BAout(ctl[4]),
      .Csignout(ctl[5]), .PCin(ctl[6]), .IRin(ctl[7]), .MARin(ctl[8]), .MDRin(ctl[9]),
      .Yin(ctl[10]), .Zlowin(ctl[11]), .Zhighin(ctl[12]), .Rin(ctl[13]), .Gra(ctl[14]),
      .Grb(ctl[15]), .Grc(ctl[16]), .IncPC(ctl[17]), .ADD(ctl[18]), .MD_read(ctl[19]),
      .MAR_clear(ctl[20]), .Read(ctl[21]), .Write(ctl[22]),
      .BusMuxOut(BusMuxOut), .IRval(IRval)
   );

   int n_cmp = 0, n_err = 0;
   logic [31:0] m_r [16];
   logic [31:0] m_pc;
   logic [31:0] prog [NPROG];
   int          kind [NPROG];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got no finish want finish within time limit");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic step(input ctl_t c);
      @(negedge clock); ctl = c;
      @(posedge clock); #1; ctl = '0;
   endtask

   task automatic step_chk(input ctl_t c, input string tag, input logic [31:0] exp);
      @(negedge clock); ctl = c; #1;
      chk(tag, BusMuxOut, exp);
      @(posedge clock); #1; ctl = '0;
   endtask

   task automatic peek(input ctl_t c);
      @(negedge clock); ctl = c; #1;
   endtask

   function automatic logic [31:0] sext(input logic [31:0] w);
      return {{13{w[18]}}, w[18:0]};
   endfunction

   function automatic logic [31:0] ba(input logic [3:0] r);
      return (r == 4'd0) ? 32'h0 : m_r[r];
   endfunction

   function automatic logic [31:0] mk(input int op, input int ra, input int rb, input logic [18:0] c);
      return {5'(op), 4'(ra), 4'(rb), c};
   endfunction

   // builds v in R0 by shift-and-increment, using only sel = 0 paths
   task automatic build(input logic [31:0] v);
      bit started = 1'b0;
      step(C_RIN);
      for (int i = 31; i >= 0; i--) begin
         if (started) begin
            step(C_ROUT | C_YIN);
            step(C_ROUT | C_ADD | C_ZLOWIN);
            step(C_ZLOWOUT | C_RIN);
         end
         if (v[i]) begin
            step(C_ROUT | C_INCPC | C_ZLOWIN);
            step(C_ZLOWOUT | C_RIN);
            started = 1'b1;
         end
      end
   endtask

   task automatic poke(input logic [8:0] a, input logic [31:0] d);
      build({23'b0, a});
      step(C_ROUT | C_MARIN);
      build(d);
      step(C_ROUT | C_MDRIN);
      step(C_WRITE);
   endtask

   task automatic fetch(input logic [31:0] exp_ir);
      step_chk(C_PCOUT | C_MARIN | C_INCPC | C_ZLOWIN, "t0_pc", m_pc);
      step(C_ZLOWOUT | C_PCIN | C_MEMRD);
      step(C_MDROUT | C_IRIN);
      chk("ir", IRval, exp_ir);
      m_pc = m_pc + 1;
   endtask

   task automatic exec(input logic [31:0] w, input int k);
      logic [3:0]  ra, rb, rc;
      logic [31:0] a, b;
      logic [32:0] s;
      ra = w[26:23]; rb = w[22:19]; rc = w[18:15];
      a = ba(rb);
      b = (k == 2) ? ba(rc) : sext(w);
      s = {1'b0, a} + {1'b0, b};
      step_chk(C_GRB | C_BAOUT | C_YIN, "t3_ba_rb", a);
      if (k == 2) step_chk(C_GRC | C_BAOUT | C_ADD | C_ZLOWIN | C_ZHIGHIN, "t4_ba_rc", b);
      else        step_chk(C_CSIGN | C_ADD | C_ZLOWIN | C_ZHIGHIN, "t4_csign", b);
      chk("zhigh", dut.zh_q, {31'b0, s[32]});
      step_chk(C_ZLOWOUT | C_GRA | C_RIN, "t5_zlow", s[31:0]);
      m_r[ra] = s[31:0];
      peek(C_GRA | C_ROUT);
      chk("rout_ra", BusMuxOut, m_r[ra]);
   endtask

   initial begin
      ctl   = '0;
      clear = 1'b1;
      m_pc  = '0;
      for (int i = 0; i < 16; i++) m_r[i] = '0;

      prog[0] = 32'h0900_0065;               kind[0] = 0;
      prog[1] = mk(1, 1, 0, 19'd2);          kind[1] = 0;
      prog[2] = mk(3, 8, 1, 19'h7FFFF);      kind[2] = 1;
      prog[3] = mk(1, 4, 0, 19'd5);          kind[3] = 0;
      prog[4] = mk(1, 5, 0, 19'd7);          kind[4] = 0;
      prog[5] = {5'd4, 4'd3, 4'd4, 4'd5, 15'd0}; kind[5] = 2;
      prog[6] = mk(1, 0, 0, 19'h1234);       kind[6] = 0;
      prog[7] = mk(1, 7, 0, 19'd500);        kind[7] = 0;
      prog[8] = mk(0, 6, 7, 19'd3);          kind[8] = 3;
      for (int i = 9; i < NPROG; i++) begin
         kind[i] = int'($urandom_range(2, 0));
         prog[i] = mk(int'($urandom_range(31, 0)), int'($urandom_range(15, 0)),
                      (kind[i] == 0) ? 0 : int'($urandom_range(15, 0)), 19'($urandom));
      end

      // power-on reset
      #2 clear = 1'b0; ctl = C_PCOUT; #1;
      chk("rst_bus_pc", BusMuxOut, 32'h0);
      chk("rst_irval", IRval, 32'h0);
      repeat (2) @(posedge clock);
      @(negedge clock); clear = 1'b1; ctl = '0;
      peek(C_PCOUT);
      chk("pc_after_rst", BusMuxOut, 32'h0);

      for (int i = 0; i < NPROG; i++) poke(9'(i), prog[i]);
      poke(9'd500, 32'hDEAD_BEEF);

      // reset again: registers clear, memory keeps the program
      @(negedge clock); clear = 1'b0; ctl = C_MDROUT; #1;
      chk("rst_bus_mdr", BusMuxOut, 32'h0);
      repeat (2) @(posedge clock);
      @(negedge clock); clear = 1'b1; ctl = '0;
      peek(C_ROUT);
      chk("rst_r0", BusMuxOut, 32'h0);

      fetch(prog[0]);
      chk("fetch_ir_lit", IRval, 32'h0900_0065);
      peek(C_PCOUT);
      chk("fetch_pc1", BusMuxOut, 32'h1);
      exec(prog[0], kind[0]);
      chk("ldi_r2_lit", BusMuxOut, 32'h65);

      fetch(prog[1]); exec(prog[1], kind[1]);
      fetch(prog[2]);
      peek(C_CSIGN);
      chk("csign_lit", BusMuxOut, 32'hFFFF_FFFF);
      exec(prog[2], kind[2]);
      chk("addi_carry_lit", dut.zh_q, 32'h1);
      chk("addi_zlow_lit", BusMuxOut, 32'h1);

      fetch(prog[3]); exec(prog[3], kind[3]);
      fetch(prog[4]); exec(prog[4], kind[4]);
      fetch(prog[5]); exec(prog[5], kind[5]);
      chk("add_r3_lit", BusMuxOut, 32'd12);

      fetch(prog[6]); exec(prog[6], kind[6]);
      peek(C_BAOUT);
      chk("ba_sel0", BusMuxOut, 32'h0);
      peek(C_ROUT);
      chk("rout_sel0", BusMuxOut, 32'h1234);

      fetch(prog[7]); exec(prog[7], kind[7]);
      fetch(prog[8]);

      // memory path
      step(C_GRB | C_ROUT | C_MARIN);
      step(C_MEMRD);
      step(C_MDROUT | C_GRA | C_RIN);
      m_r[6] = 32'hDEAD_BEEF;
      step(C_MDRIN);
      peek(C_MDROUT);
      chk("mdr_zero", BusMuxOut, 32'h0);
      step(C_GRA | C_ROUT | C_MDRIN);
      step(C_CSIGN | C_MARIN);
      step(C_WRITE);
      step(C_MDRIN);
      step(C_MEMRD);
      peek(C_MDROUT);
      chk("mem3_rd", BusMuxOut, 32'hDEAD_BEEF);
      step(C_MDRIN);
      step(C_WRITE);
      step(C_GRA | C_ROUT | C_MDRIN | C_WRITE);
      step(C_MEMRD);
      peek(C_MDROUT);
      chk("wr_old_mdr", BusMuxOut, 32'h0);
      step(C_GRA | C_ROUT | C_MDRIN);
      step(C_MEMRD | C_WRITE);
      peek(C_MDROUT);
      chk("rw_pre_write", BusMuxOut, 32'h0);
      step(C_MEMRD);
      peek(C_MDROUT);
      chk("rw_post_write", BusMuxOut, 32'hDEAD_BEEF);
      step(C_CSIGN | C_MARIN | C_MARCLR);
      step(C_MEMRD);
      peek(C_MDROUT);
      chk("mar_clear", BusMuxOut, 32'h0900_0065);

      for (int i = 9; i < NPROG; i++) begin
         fetch(prog[i]);
         exec(prog[i], kind[i]);
      end

      // reset landing on a cycle with loads pending
      @(negedge clock); ctl = C_GRA | C_ROUT | C_PCIN | C_YIN | C_IRIN; clear = 1'b0; #1;
      chk("rst_mid_bus", BusMuxOut, 32'h0);
      @(posedge clock);
      @(negedge clock); clear = 1'b1; ctl = '0;
      peek(C_PCOUT);
      chk("rst_mid_pc", BusMuxOut, 32'h0);
      chk("rst_mid_ir", IRval, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
